// File: rtl/memory_responder.sv
// memory_responder: word-addressed synchronous RAM behind the MAR/MDR interface.
// A request is latched in IDLE, waits WAIT_STATES extra cycles, performs the
// access, then pulses mem_ready for one cycle in DONE.
module memory_responder #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] mem_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    next_count;
    logic                capture_c;
    logic                access_c;

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                is_write_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Address bits above ADDR_W-1 are deliberately ignored (aliasing).
    logic                unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[31:ADDR_W];

    // Next-state and wait-counter logic
    always_comb begin
        next_state = state;
        next_count = count;
        capture_c  = 1'b0;
        access_c   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write || mem_read) begin
                    capture_c  = 1'b1;
                    next_count = CNT_W'(WAIT_STATES);
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (count != CNT_W'(0)) begin
                    next_count = count - CNT_W'(1);
                end else begin
                    access_c   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_count = CNT_W'(0);
            end
        endcase
    end

    // State register plus registered handshake outputs
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            count     <= CNT_W'(0);
            mem_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            count     <= next_count;
            mem_ready <= (next_state == DONE);
            busy      <= (next_state != IDLE);
        end
    end

    // Request capture; write wins when both request lines are high
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            addr_q     <= ADDR_W'(0);
            data_q     <= DATA_W'(0);
            is_write_q <= 1'b0;
        end else if (capture_c) begin
            addr_q     <= mem_addr[ADDR_W-1:0];
            data_q     <= write_data;
            is_write_q <= mem_write;
        end
    end

    // Storage array; contents are not reset
    always_ff @(posedge clock) begin
        if (access_c && is_write_q) begin
            mem[addr_q] <= data_q;
        end
    end

    // Load data register, updated only by a completed read
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            read_data <= DATA_W'(0);
        end else if (access_c && !is_write_q) begin
            read_data <= mem[addr_q];
        end
    end

endmodule
